// File: rtl/adder_pkg.sv
// Shared defaults and result type for the adder block.
package adder_pkg;

    localparam int WIDTH_DEF     = 4;
    localparam int ACC_WIDTH_DEF = 8;

    // Result of one addition at the default operand width: carry-out in the MSB.
    typedef logic [WIDTH_DEF:0] sum_t;

    // Occupancy of the two-entry result queue.
    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_level_e;

endpackage

// File: rtl/adder_fifo.sv
// Two-entry valid/ready queue holding registered adder results.
// Storage is not reset; occupancy and pointers are, and the output
// is forced to zero while the queue is empty.
module adder_fifo
    import adder_pkg::*;
#(
    parameter int DATA_W = WIDTH_DEF + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] mem_p1 [2];
    logic              wr_ptr;
    logic              rd_ptr;
    fifo_level_e       level;
    logic              push;
    logic              pop;

    // Handshake decode: a full queue refuses pushes even when popping.
    always_comb begin
        in_ready  = (level != FIFO_FULL);
        out_valid = (level != FIFO_EMPTY);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_data  = out_valid ? mem_p1[rd_ptr] : '0;
    end

    // Data storage: written on every accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_p1[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; reset empties the queue immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            level  <= FIFO_EMPTY;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10: level <= (level == FIFO_EMPTY) ? FIFO_ONE : FIFO_FULL;
                2'b01: level <= (level == FIFO_FULL) ? FIFO_ONE : FIFO_EMPTY;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/adder.sv
// Unsigned adder with a combinational sum, a registered two-entry
// result queue, and a saturating running accumulator.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH:0]       sum,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH:0]       out_sum,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 acc_sat
);

    typedef logic [WIDTH:0] res_t;

    res_t                 sum_p0;
    logic                 accept_p0;
    logic [ACC_WIDTH:0]   acc_next_p0;
    logic [ACC_WIDTH-1:0] acc_p1;
    logic                 sat_p1;

    // Saturating accumulate: MSB of the result flags a clamp, the rest is
    // min(acc + s, 2^ACC_WIDTH-1). ACC_WIDTH >= WIDTH+1 so s always fits.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] cur,
                                                   input res_t s);
        logic [ACC_WIDTH:0] ext;
        logic [ACC_WIDTH:0] wide;
        ext          = '0;
        ext[WIDTH:0] = s;
        wide         = {1'b0, cur} + ext;
        if (wide[ACC_WIDTH]) begin
            sat_add = {1'b1, {ACC_WIDTH{1'b1}}};
        end else begin
            sat_add = {1'b0, wide[ACC_WIDTH-1:0]};
        end
    endfunction

    // Combinational sum, independent of clock and reset.
    always_comb begin
        sum_p0      = res_t'(a) + res_t'(b);
        sum         = sum_p0;
        accept_p0   = in_valid && in_ready;
        acc_next_p0 = sat_add(acc_p1, sum_p0);
    end

    // Result queue: accepted sums land on out_sum one edge later.
    adder_fifo #(
        .DATA_W (WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (sum_p0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_sum)
    );

    // Accumulator: clear wins over accumulate; saturation flag is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p1 <= '0;
            sat_p1 <= 1'b0;
        end else if (acc_clr) begin
            acc_p1 <= '0;
            sat_p1 <= 1'b0;
        end else if (accept_p0 && acc_en) begin
            acc_p1 <= acc_next_p0[ACC_WIDTH-1:0];
            sat_p1 <= sat_p1 | acc_next_p0[ACC_WIDTH];
        end
    end

    // Registered accumulator state drives the ports directly.
    always_comb begin
        acc     = acc_p1;
        acc_sat = sat_p1;
    end

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for adder: stimulus queues expected results, a
// negedge monitor pops and compares on each output handshake.
module tb_adder;
    import adder_pkg::*;

    localparam int W  = WIDTH_DEF;
    localparam int AW = ACC_WIDTH_DEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [W:0]    sum;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W:0]    out_sum;
    logic          acc_en = 1'b0;
    logic          acc_clr = 1'b0;
    logic [AW-1:0] acc;
    logic          acc_sat;

    int   vectors = 0;
    int   miscompares = 0;
    sum_t exp_q[$];
    sum_t mon_exp;

    adder #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .acc       (acc),
        .acc_sat   (acc_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every output handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL out_sum_unexpected: got %0d, expected no result", out_sum);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_sum_order", int'(out_sum), int'(mon_exp));
            end
        end
    end

    // Offer one pair, hold until accepted, queue its expected result.
    task automatic offer(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input int exp_sum, output int waited);
        logic ok;
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        waited   = 0;
        forever begin
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                exp_q.push_back(sum_t'(exp_sum));
                break;
            end
            waited++;
            if (waited > 20) begin
                vectors++;
                miscompares++;
                $display("FAIL offer_timeout: got in_ready=0 for %0d cycles, expected acceptance", waited);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; int s; } vec_t;

    vec_t comb_tab[10];
    vec_t stream_tab[4];
    int   w;

    initial begin
        comb_tab = '{'{4'd1, 4'd2, 3}, '{4'd7, 4'd9, 16}, '{4'd8, 4'd8, 16},
                     '{4'd15, 4'd1, 16}, '{4'd5, 4'd10, 15}, '{4'd12, 4'd13, 25},
                     '{4'd6, 4'd6, 12}, '{4'd14, 4'd3, 17}, '{4'd9, 4'd0, 9},
                     '{4'd11, 4'd15, 26}};
        stream_tab = '{'{4'd6, 4'd7, 13}, '{4'd15, 4'd0, 15},
                       '{4'd10, 4'd10, 20}, '{4'd13, 4'd14, 27}};

        // Reset state, no edge needed
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_acc", acc, 0);
        check("rst_acc_sat", acc_sat, 0);
        check("rst_in_ready", in_ready, 1);

        // Combinational sum
        a = 4'hF; b = 4'hF; #1;
        check("sum_max", sum, 30);
        a = 4'h0; b = 4'h0; #1;
        check("sum_zero", sum, 0);
        foreach (comb_tab[i]) begin
            a = comb_tab[i].a;
            b = comb_tab[i].b;
            #5;
            check("sum_table", sum, comb_tab[i].s);
        end

        // Release reset mid-cycle, then single transaction with 1-cycle latency
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        offer(4'd3, 4'd4, 7, w);
        check("lat_out_valid", out_valid, 1);
        check("lat_out_sum", out_sum, 7);
        @(posedge clk); #1;
        check("lat_out_valid_fall", out_valid, 0);

        // Backpressure: two accepted, third held until space frees
        out_ready = 1'b0;
        offer(4'd1, 4'd1, 2, w);
        check("bp_first_wait", w, 0);
        offer(4'd2, 4'd3, 5, w);
        check("bp_full_in_ready", in_ready, 0);
        in_valid = 1'b1; a = 4'd4; b = 4'd4;
        repeat (2) begin
            @(posedge clk); #1;
            check("bp_held_in_ready", in_ready, 0);
            check("bp_held_out_sum", out_sum, 2);
            check("bp_held_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_pop_in_ready", in_ready, 1);
        check("bp_pop_out_sum", out_sum, 5);
        exp_q.push_back(sum_t'(8));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_third_out_sum", out_sum, 8);
        repeat (2) @(posedge clk);
        #1;
        check("bp_drained", out_valid, 0);

        // Back-to-back push+pop keeps occupancy at one
        foreach (stream_tab[i]) begin
            offer(stream_tab[i].a, stream_tab[i].b, stream_tab[i].s, w);
            check("stream_in_ready", in_ready, 1);
            check("stream_out_sum", out_sum, stream_tab[i].s);
        end
        @(posedge clk); #1;

        // Saturating accumulator
        acc_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            offer(4'd15, 4'd15, 30, w);
            check("acc_value", acc, (30 * k > 255) ? 255 : 30 * k);
            check("acc_sat_flag", acc_sat, (k >= 9) ? 1 : 0);
        end
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        check("acc_clr_value", acc, 0);
        check("acc_clr_sat", acc_sat, 0);
        acc_clr = 1'b1;
        offer(4'd1, 4'd2, 3, w);
        acc_clr = 1'b0;
        check("acc_clr_priority", acc, 0);
        offer(4'd2, 4'd2, 4, w);
        check("acc_after_clr", acc, 4);
        acc_en = 1'b0;
        offer(4'd7, 4'd7, 14, w);
        check("acc_en_off", acc, 4);
        @(posedge clk); #1;

        // Asynchronous reset with two queued results
        out_ready = 1'b0;
        offer(4'd1, 4'd3, 4, w);
        offer(4'd2, 4'd6, 8, w);
        check("prerst_out_valid", out_valid, 1);
        a = 4'd9; b = 4'd8;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_sum", out_sum, 0);
        check("midrst_acc", acc, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_sum", sum, 17);
        exp_q.delete();

        // First acceptance on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 4'd5; b = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("postrst_out_valid", out_valid, 1);
        check("postrst_out_sum", out_sum, 11);
        exp_q.push_back(sum_t'(11));
        repeat (3) @(posedge clk);
        #1;
        check("final_out_valid", out_valid, 0);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog against any unforeseen hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter WIDTH, default 4; operand width in bits.
REQ-002 Parameter ACC_WIDTH, default 8; accumulator width in bits; ACC_WIDTH SHALL be at least WIDTH+1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 a  input  WIDTH  unsigned operand A.
REQ-006 b  input  WIDTH  unsigned operand B.
REQ-007 sum  output  WIDTH+1  combinational a+b, including carry-out in the MSB.
REQ-008 in_valid  input  1  the a/b pair is offered to the registered path.
REQ-009 in_ready  output  1  the registered path can accept a pair.
REQ-010 out_valid  output  1  out_sum holds a valid result.
REQ-011 out_ready  input  1  downstream consumes out_sum.
REQ-012 out_sum  output  WIDTH+1  registered result at the head of the result queue.
REQ-013 acc_en  input  1  add each accepted sum into the accumulator.
REQ-014 acc_clr  input  1  synchronous accumulator clear.
REQ-015 acc  output  ACC_WIDTH  running accumulator value.
REQ-016 acc_sat  output  1  sticky flag: the accumulator has saturated.

Function
REQ-017 sum SHALL equal zero-extended a plus zero-extended b, unsigned, with no wrap; e.g. 4'hF+4'hF = 5'd30.
REQ-018 sum SHALL be purely combinational, independent of clk and rst_n, and settle within the same time step as an input change.
REQ-019 A pair is accepted on a rising edge where in_valid && in_ready; the value a+b at that edge SHALL be pushed into a 2-entry result queue.
REQ-020 Latency: a pair accepted at edge N SHALL appear on out_sum with out_valid=1 after edge N (1 cycle).
REQ-021 A result is popped on a rising edge where out_valid && out_ready; out_sum SHALL then show the next entry, or out_valid SHALL fall if the queue is empty.
REQ-022 in_ready SHALL be 1 exactly when the queue holds fewer than 2 entries; when the queue is full, no push SHALL occur even if a pop occurs at the same edge.
REQ-023 A simultaneous push and pop on a non-full queue SHALL keep the occupancy unchanged and preserve FIFO order.
REQ-024 out_valid SHALL be 1 exactly when the queue is non-empty; out_sum SHALL hold steady while out_valid && !out_ready.
REQ-025 On an accepted pair with acc_en=1, acc SHALL become min(acc + sum, 2^ACC_WIDTH-1); if the value clamps, acc_sat SHALL be set.
REQ-026 acc_sat SHALL remain set until acc_clr or reset.
REQ-027 acc_clr=1 SHALL set acc=0 and acc_sat=0 at the edge and SHALL take priority over a simultaneous accumulate.
REQ-028 acc_en and acc_clr SHALL have no effect on the queue.

Reset
REQ-029 While rst_n=0: queue empty, out_valid=0, out_sum=0, acc=0, acc_sat=0, in_ready=1; assertion takes effect immediately without a clock edge.
REQ-030 Reset asserted mid-operation SHALL discard all queued results; sum SHALL continue to track a+b during reset.
REQ-031 Release of rst_n SHALL be assumed synchronous to clk; the first acceptance SHALL be possible on the first edge after release.

Structure
REQ-032 A shared package adder_pkg SHALL hold the WIDTH/ACC_WIDTH defaults and a typedef for the (WIDTH+1)-bit result.
REQ-033 The 2-entry result queue SHALL be a sub-module adder_fifo (parameterized data width, depth 2, valid/ready on both sides).
REQ-034 The combinational adder, accumulator and control logic SHALL reside in adder itself.

Verification
REQ-035 a=4'hF, b=4'hF, no clock -> sum=5'd30 within one time step; a=0, b=0 -> sum=0.
REQ-036 Ten random a/b pairs, check 5 time units after each change -> sum == a+b every time.
REQ-037 in_valid=1 with a=3, b=4 for one edge, out_ready=1 -> out_valid=1, out_sum=7 after 1 cycle, then out_valid=0.
REQ-038 out_ready=0, three pairs offered -> in_ready=0 after 2 accepts; 3rd pair held; results drain in order once out_ready=1.
REQ-039 ACC_WIDTH=8, acc_en=1, repeated 15+15 accepts -> acc goes 30,60,...,240, then 255 with acc_sat=1; acc_clr -> acc=0, acc_sat=0.
REQ-040 rst_n pulled low with 2 queued results -> out_valid=0, acc=0, in_ready=1 immediately, with sum unaffected.
